cmd_fetch: RTL and testbench

- Upstream neighbour of the command-word decoder. Fetches one 32-bit command word per instruction from the program memory bus and holds it stable on command_word for the decoder.
- Maintains the instruction pointer (ip). Offers each word to the execute stage with a valid/ready handshake.
- Supports redirect (jump) with safe flushing of an in-flight memory read.

---
 rtl/cmd_fetch.sv | 160 ++++++++++++++++
 tb/tb_cmd_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fetch.sv
// cmd_fetch: fetches one 32-bit command word per instruction from the program
// memory bus, holds it for the decoder and offers it to the execute stage with
// a valid/ready handshake. A redirect (jump) may arrive at any time; a read
// already on the bus is always completed and its data dropped when a jump
// overtook it.
module cmd_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_IP = '0,
    parameter logic [ADDR_W-1:0]  IP_STEP  = ADDR_W'(32'd1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic [31:0]       command_word,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              run,
    output logic [ADDR_W-1:0] ip,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   ip_r;
    logic [ADDR_W-1:0]   ip_s;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic                mem_rd_r;
    logic                mem_rd_s;
    logic [31:0]         command_word_r;
    logic [31:0]         command_word_s;
    logic                cmd_valid_r;
    logic                cmd_valid_s;
    // flush_r marks the outstanding read as stale: a jump arrived after it was issued
    logic                flush_r;
    logic                flush_s;
    logic                busy_r;

    // Next-state and next-output computation; every register holds by default
    always_comb begin
        state_s        = state_r;
        ip_s           = ip_r;
        mem_addr_s     = mem_addr_r;
        mem_rd_s       = mem_rd_r;
        command_word_s = command_word_r;
        cmd_valid_s    = cmd_valid_r;
        flush_s        = flush_r;

        case (state_r)
            IDLE: begin
                if (jump) begin
                    // Redirect takes one idle cycle before the new fetch starts
                    ip_s = jump_addr;
                end else if (run) begin
                    state_s    = REQ;
                    mem_rd_s   = 1'b1;
                    mem_addr_s = ip_r;
                end else begin
                    state_s = IDLE;
                end
            end

            REQ: begin
                if (mem_ack) begin
                    mem_rd_s = 1'b0;
                    if (jump) begin
                        // Data arriving together with a redirect is already stale
                        ip_s    = jump_addr;
                        flush_s = 1'b0;
                        state_s = IDLE;
                    end else if (flush_r) begin
                        // ip already holds the jump target
                        flush_s = 1'b0;
                        state_s = IDLE;
                    end else begin
                        command_word_s = mem_data;
                        cmd_valid_s    = 1'b1;
                        ip_s           = ip_r + IP_STEP;
                        state_s        = HOLD;
                    end
                end else if (jump) begin
                    // The bus read cannot be aborted; remember to drop its data
                    ip_s    = jump_addr;
                    flush_s = 1'b1;
                end else begin
                    state_s = REQ;
                end
            end

            HOLD: begin
                if (jump) begin
                    // Redirect wins over a simultaneous handshake
                    cmd_valid_s = 1'b0;
                    ip_s        = jump_addr;
                    state_s     = IDLE;
                end else if (cmd_valid_r && cmd_ready) begin
                    cmd_valid_s = 1'b0;
                    if (run) begin
                        state_s    = REQ;
                        mem_rd_s   = 1'b1;
                        mem_addr_s = ip_r;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = HOLD;
                end
            end

            default: begin
                state_s     = IDLE;
                mem_rd_s    = 1'b0;
                cmd_valid_s = 1'b0;
                flush_s     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            ip_r           <= RESET_IP;
            mem_addr_r     <= RESET_IP;
            mem_rd_r       <= 1'b0;
            command_word_r <= 32'd0;
            cmd_valid_r    <= 1'b0;
            flush_r        <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            ip_r           <= ip_s;
            mem_addr_r     <= mem_addr_s;
            mem_rd_r       <= mem_rd_s;
            command_word_r <= command_word_s;
            cmd_valid_r    <= cmd_valid_s;
            flush_r        <= flush_s;
            busy_r         <= (state_s == REQ);
        end
    end

    assign mem_addr     = mem_addr_r;
    assign mem_rd       = mem_rd_r;
    assign command_word = command_word_r;
    assign cmd_valid    = cmd_valid_r;
    assign ip           = ip_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_cmd_fetch.sv
// Bench for cmd_fetch: directed stimulus with a scoreboard of expected command
// words and a negedge monitor that checks every word the DUT presents.
// A second instance with RESET_IP = all-ones covers ip wrap-around.
module tb_cmd_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] command_word;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = 32'd0;
    logic        run = 1'b0;
    logic [31:0] ip;
    logic        busy;

    logic        w_rst = 1'b1;
    logic [31:0] w_mem_addr;
    logic        w_mem_rd;
    logic        w_mem_ack;
    logic [31:0] w_mem_data;
    logic [31:0] w_command_word;
    logic        w_cmd_valid;
    logic        w_cmd_ready = 1'b0;
    logic        w_run = 1'b0;
    logic [31:0] w_ip;
    logic        w_busy;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] q[$];
    logic [31:0] wq[$];

    int   ack_delay = 0;
    int   cnt = 0;
    logic force_ack = 1'b0;
    logic pv = 1'b0;
    logic wpv = 1'b0;

    always #5 clk = ~clk;

    cmd_fetch #(.ADDR_W(32), .RESET_IP(32'h0000_0000), .IP_STEP(32'd1)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_data(mem_data), .command_word(command_word),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .jump(jump),
        .jump_addr(jump_addr), .run(run), .ip(ip), .busy(busy)
    );

    cmd_fetch #(.ADDR_W(32), .RESET_IP(32'hFFFF_FFFF), .IP_STEP(32'd1)) u_wrap (
        .clk(clk), .rst(w_rst), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd),
        .mem_ack(w_mem_ack), .mem_data(w_mem_data), .command_word(w_command_word),
        .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .jump(1'b0),
        .jump_addr(32'd0), .run(w_run), .ip(w_ip), .busy(w_busy)
    );

    // Program memory contents
    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h1000_0001;
            32'd1:   return 32'h2000_0002;
            32'd2:   return 32'h3000_0003;
            default: return {8'hC0, a[23:0]};
        endcase
    endfunction

    // Memory model: ack after ack_delay cycles of mem_rd; force_ack injects a stray ack
    assign mem_ack  = (mem_rd && (cnt == ack_delay)) || force_ack;
    assign mem_data = mem_ack ? memword(mem_addr) : 32'hDEAD_BEEF;
    assign w_mem_ack  = w_mem_rd;
    assign w_mem_data = w_mem_ack ? memword(w_mem_addr) : 32'hDEAD_BEEF;

    // Wait-state counter for the memory model
    always @(posedge clk) begin
        if (!mem_rd || mem_ack) cnt <= 0;
        else                    cnt <= cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each newly presented word is popped and compared
    always @(negedge clk) begin
        if (cmd_valid === 1'b1 && !pv) begin
            if (q.size() == 0) chk("unexpected_word", command_word, 32'hFFFF_FFFF);
            else               chk("cmd_word", command_word, q.pop_front());
        end
        if (w_cmd_valid === 1'b1 && !wpv) begin
            if (wq.size() == 0) chk("w_unexpected_word", w_command_word, 32'hFFFF_FFFF);
            else                chk("w_cmd_word", w_command_word, wq.pop_front());
        end
        pv  = (cmd_valid === 1'b1);
        wpv = (w_cmd_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && cmd_valid !== 1'b1; i++) tick();
        chk("wait_valid", 32'(cmd_valid), 32'd1);
    endtask

    initial begin
        // Reset and sequential fetch
        tick(); tick();
        chk("rst_mem_rd",  32'(mem_rd), 32'd0);
        chk("rst_valid",   32'(cmd_valid), 32'd0);
        chk("rst_ip",      ip, 32'd0);
        chk("rst_addr",    mem_addr, 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_cw",      command_word, 32'd0);
        rst = 1'b0; run = 1'b1; cmd_ready = 1'b1; ack_delay = 0;
        q.push_back(32'h1000_0001); q.push_back(32'h2000_0002); q.push_back(32'h3000_0003);
        tick();
        chk("first_rd", {30'd0, mem_rd, busy}, 32'd3);
        chk("first_addr", mem_addr, 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_valid(10);
            chk("seq_ip", ip, 32'(k + 1));
            if (k == 2) run = 1'b0;
            tick();
        end
        chk("seq_idle", {30'd0, mem_rd, cmd_valid}, 32'd0);
        chk("cw_kept", command_word, 32'h3000_0003);

        // Memory wait states and backpressure
        cmd_ready = 1'b0; jump = 1'b1; jump_addr = 32'd0;
        tick();
        jump = 1'b0;
        chk("idle_jump_ip", ip, 32'd0);
        ack_delay = 4; run = 1'b1; q.push_back(32'h1000_0001);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("wait_stable", {mem_rd, cmd_valid, mem_addr[29:0]}, 32'h8000_0000);
            tick();
        end
        chk("wait_done_ip", ip, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {30'd0, cmd_valid, mem_rd}, 32'd2);
            chk("bp_cw", command_word, 32'h1000_0001);
            tick();
        end
        cmd_ready = 1'b1; run = 1'b0;
        tick();
        chk("bp_release", {30'd0, mem_rd, cmd_valid}, 32'd0);

        // Jump during an outstanding read
        cmd_ready = 1'b0; jump = 1'b1; jump_addr = 32'd5;
        tick();
        jump = 1'b0; ack_delay = 2; run = 1'b1;
        q.push_back(32'hC000_0040);
        tick();
        chk("req5_addr", mem_addr, 32'd5);
        jump = 1'b1; jump_addr = 32'h40;
        tick();
        jump = 1'b0;
        chk("jreq_ip", ip, 32'h40);
        chk("jreq_addr", mem_addr, 32'd5);
        chk("jreq_rd", 32'(mem_rd), 32'd1);
        tick();
        tick();
        chk("flush_idle", {30'd0, mem_rd, cmd_valid}, 32'd0);
        tick();
        chk("refetch_addr", mem_addr, 32'h40);
        chk("refetch_rd", 32'(mem_rd), 32'd1);
        wait_valid(10);
        chk("refetch_ip", ip, 32'h41);

        // Jump and cmd_ready together in HOLD
        cmd_ready = 1'b1; jump = 1'b1; jump_addr = 32'h80; ack_delay = 0;
        tick();
        jump = 1'b0;
        chk("hj_valid", 32'(cmd_valid), 32'd0);
        chk("hj_rd", 32'(mem_rd), 32'd0);
        chk("hj_ip", ip, 32'h80);
        q.push_back(32'hC000_0080);
        tick();
        chk("hj_addr", mem_addr, 32'h80);
        wait_valid(10);
        chk("hj_next_ip", ip, 32'h81);
        run = 1'b0;
        tick();

        // Jump coinciding with mem_ack: data dropped
        run = 1'b1;
        tick();
        jump = 1'b1; jump_addr = 32'h90; run = 1'b0;
        tick();
        jump = 1'b0;
        chk("ja_idle", {30'd0, mem_rd, cmd_valid}, 32'd0);
        chk("ja_ip", ip, 32'h90);
        tick();
        chk("ja_stay", 32'(cmd_valid), 32'd0);

        // Reset mid-read with a late ack
        ack_delay = 3; run = 1'b1;
        tick();
        chk("mr_rd", 32'(mem_rd), 32'd1);
        run = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_after", {29'd0, mem_rd, cmd_valid, busy}, 32'd0);
        chk("mr_ip", ip, 32'd0);
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("late_ack", {30'd0, mem_rd, cmd_valid}, 32'd0);
        chk("late_ip", ip, 32'd0);
        ack_delay = 0; run = 1'b1; cmd_ready = 1'b1;
        q.push_back(32'h1000_0001);
        tick();
        wait_valid(10);
        run = 1'b0;
        tick();

        // Wrap-around instance and run gating
        wq.push_back(32'hC0FF_FFFF);
        w_run = 1'b1; w_rst = 1'b0;
        tick();
        chk("w_addr", w_mem_addr, 32'hFFFF_FFFF);
        tick();
        chk("w_ip_wrap", w_ip, 32'd0);
        chk("w_valid", 32'(w_cmd_valid), 32'd1);
        w_run = 1'b0; w_cmd_ready = 1'b1;
        tick();
        chk("w_idle", {29'd0, w_mem_rd, w_cmd_valid, w_busy}, 32'd0);
        tick();
        chk("w_idle2", 32'(w_mem_rd), 32'd0);
        wq.push_back(32'h1000_0001);
        w_run = 1'b1;
        tick();
        chk("w_resume_addr", w_mem_addr, 32'd0);
        chk("w_resume_rd", 32'(w_mem_rd), 32'd1);
        tick();
        chk("w_resume_ip", w_ip, 32'd1);
        w_run = 1'b0;
        tick(); tick();

        chk("sb_empty", 32'(q.size()), 32'd0);
        chk("w_sb_empty", 32'(wq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
